// File: rtl/bus_mem_responder.sv
// ---------------------------------------------------------------------------
// bus_mem_responder
//
// Single-port word memory behind a simple start/mode bus. The initiator
// pulses BUS_start_transaction while the block is idle; the block latches
// mode, address and write data, waits LATENCY cycles, services the access
// in a one-cycle RESP state, and reports completion with a one-cycle pulse.
//
// Ports
//   clk                   : clock, rising edge active
//   rst_n                 : asynchronous active-low reset
//   BUS_start_transaction : request strobe, honoured only while idle
//   BUS_mode              : 0 = read, 1 = write
//   BUS_addr  [ADDR_W]    : word address
//   BUS_wdata [DATA_W]    : write data
//   BUS_rdata [DATA_W]    : read data, held until the next read completes
//   BUS_rdata_valid       : one-cycle read-complete pulse
//   BUS_write_done        : one-cycle write-complete pulse
//   BUS_busy              : high while a transaction is pending (WAIT/RESP)
//
// Timing: a start sampled at edge k puts the block in RESP for the cycle
// between edges k+LATENCY and k+LATENCY+1; the access is performed at edge
// k+LATENCY+1, so the completion pulse spans k+LATENCY+1 .. k+LATENCY+2.
// That pulse cycle is already an IDLE cycle, so a new start sampled at
// edge k+LATENCY+2 is accepted (one transaction per LATENCY+2 cycles).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bus_mem_responder #(
  parameter int    ADDR_W    = 8,
  parameter int    DATA_W    = 16,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              BUS_start_transaction,
  input  logic              BUS_mode,
  input  logic [ADDR_W-1:0] BUS_addr,
  input  logic [DATA_W-1:0] BUS_wdata,
  output logic [DATA_W-1:0] BUS_rdata,
  output logic              BUS_rdata_valid,
  output logic              BUS_write_done,
  output logic              BUS_busy
);

  localparam int         DEPTH   = 1 << ADDR_W;
  // LATENCY is limited to 0..15, so a 4-bit wait counter suffices.
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);
  localparam bit         NO_WAIT = (LATENCY == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                write_done_q, write_done_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state / output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    write_done_d  = 1'b0;
    mem_we        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (BUS_start_transaction) begin
          mode_d  = BUS_mode;
          addr_d  = BUS_addr;
          wdata_d = BUS_wdata;
          if (NO_WAIT) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_CNT;
          end
        end
      end

      WAIT: begin
        // Counter is loaded with LATENCY, so RESP is entered after exactly
        // LATENCY WAIT cycles.
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        // Access happens on the edge leaving RESP; the pulse registers make
        // the completion visible for exactly the following cycle.
        state_d = IDLE;
        if (mode_q) begin
          mem_we       = 1'b1;
          write_done_d = 1'b1;
        end else begin
          rdata_d       = mem[addr_q];
          rdata_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and visible outputs: asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      write_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      write_done_q  <= write_done_d;
    end
  end

  // Latched request and storage: no reset. mem_we is derived from state_q,
  // which reset forces to IDLE, so an aborted write can never land.
  always_ff @(posedge clk) begin
    mode_q  <= mode_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign BUS_rdata       = rdata_q;
  assign BUS_rdata_valid = rdata_valid_q;
  assign BUS_write_done  = write_done_q;
  assign BUS_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_bus_mem_responder.sv
// ---------------------------------------------------------------------------
// Testbench for bus_mem_responder.
// Instance dut uses LATENCY=2, instance dut0 uses LATENCY=0. Each transaction
// is checked cycle by cycle against timing rules derived from the latency:
// with accept at edge k, busy is high in intervals 0..L after k, and the
// completion pulse is high only in interval L+1. A plain array models the
// storage contents and a scalar models the held read data.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bus_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0, mode = 1'b0;
  logic [7:0]  addr  = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        rvalid, wdone, busy;

  logic        start0 = 1'b0, mode0 = 1'b0;
  logic [7:0]  addr0  = 8'h00;
  logic [15:0] wdata0 = 16'h0000;
  logic [15:0] rdata0;
  logic        rvalid0, wdone0, busy0;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] ref_mem  [256];
  logic [15:0] ref_rdata = 16'h0000;
  logic [15:0] ref_mem0 [256];
  logic [15:0] ref_rdata0 = 16'h0000;

  always #5 clk = ~clk;

  bus_mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n),
    .BUS_start_transaction(start), .BUS_mode(mode),
    .BUS_addr(addr), .BUS_wdata(wdata),
    .BUS_rdata(rdata), .BUS_rdata_valid(rvalid),
    .BUS_write_done(wdone), .BUS_busy(busy)
  );

  bus_mem_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst_n(rst_n),
    .BUS_start_transaction(start0), .BUS_mode(mode0),
    .BUS_addr(addr0), .BUS_wdata(wdata0),
    .BUS_rdata(rdata0), .BUS_rdata_valid(rvalid0),
    .BUS_write_done(wdone0), .BUS_busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called just after a negedge. noise: 0 = inputs idle after accept,
  // 1 = random garbage (including stray starts) while busy,
  // 2 = a competing write to 0x20/0x1234 held high while busy.
  task automatic txn(input bit m, input logic [7:0] a, input logic [15:0] d, input int noise);
    start = 1'b1; mode = m; addr = a; wdata = d;
    @(posedge clk);
    for (int j = 0; j <= LAT + 1; j++) begin
      @(negedge clk);
      if (j == LAT + 1 && !m) ref_rdata = ref_mem[a];
      chk("busy",   32'(busy),   32'(j <= LAT));
      chk("rvalid", 32'(rvalid), 32'((j == LAT + 1) && !m));
      chk("wdone",  32'(wdone),  32'((j == LAT + 1) && m));
      chk("rdata",  32'(rdata),  32'(ref_rdata));
      if (j == LAT + 1 && m) ref_mem[a] = d;
      if (j <= LAT && noise == 1) begin
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
        addr  = 8'($urandom);
        wdata = 16'($urandom);
      end else if (j <= LAT && noise == 2) begin
        start = 1'b1; mode = 1'b1; addr = 8'h20; wdata = 16'h1234;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  // LATENCY=0 instance: RESP in interval 0, pulse in interval 1.
  task automatic txn0(input bit m, input logic [7:0] a, input logic [15:0] d);
    start0 = 1'b1; mode0 = m; addr0 = a; wdata0 = d;
    @(posedge clk);
    for (int j = 0; j <= 1; j++) begin
      @(negedge clk);
      if (j == 1 && !m) ref_rdata0 = ref_mem0[a];
      chk("busy0",   32'(busy0),   32'(j == 0));
      chk("rvalid0", 32'(rvalid0), 32'((j == 1) && !m));
      chk("wdone0",  32'(wdone0),  32'((j == 1) && m));
      chk("rdata0",  32'(rdata0),  32'(ref_rdata0));
      if (j == 1 && m) ref_mem0[a] = d;
      start0 = 1'b0;
      addr0  = 8'($urandom);
      wdata0 = 16'($urandom);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_busy",   32'(busy),   32'(0));
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_wdone",  32'(wdone),  32'(0));
    chk("rst_rdata",  32'(rdata),  32'(0));
    chk("rst_busy0",  32'(busy0),  32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // LATENCY=0: writes then back-to-back reads every 2 cycles
    txn0(1'b1, 8'h10, 16'hC0DE);
    txn0(1'b1, 8'h11, 16'h5A5A);
    txn0(1'b1, 8'hFF, 16'hFFFF);
    txn0(1'b0, 8'h10, 16'h0000);
    txn0(1'b0, 8'h11, 16'h0000);
    txn0(1'b0, 8'hFF, 16'h0000);
    txn0(1'b0, 8'h10, 16'h0000);

    // Fill every word of the LATENCY=2 instance with known random data
    for (int i = 0; i < 256; i++) begin
      txn(1'b1, 8'(i), 16'($urandom), 1);
    end

    // Write 0xBEEF to 0x10 then read back at the first IDLE edge
    txn(1'b1, 8'h10, 16'hBEEF, 0);
    txn(1'b0, 8'h10, 16'h0000, 0);
    // Intervening write must not disturb held read data
    txn(1'b1, 8'h11, 16'h0001, 0);
    chk("rdata_hold", 32'(rdata), 32'(16'hBEEF));

    // Competing start to 0x20 held high through WAIT and RESP is dropped
    txn(1'b1, 8'h40, 16'h4444, 2);
    txn(1'b0, 8'h20, 16'h0000, 0);

    // Address/data changed right after accept are ignored
    txn(1'b1, 8'h50, 16'h5050, 1);
    txn(1'b0, 8'h50, 16'h0000, 1);

    // Reset during WAIT aborts a write to 0x30
    start = 1'b1; mode = 1'b1; addr = 8'h30; wdata = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_pre", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    ref_rdata = 16'h0000;
    chk("abort_busy",   32'(busy),   32'(0));
    chk("abort_rdata",  32'(rdata),  32'(0));
    chk("abort_wdone",  32'(wdone),  32'(0));
    chk("abort_rvalid", 32'(rvalid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release must accept; 0x30 keeps its prior contents
    txn(1'b0, 8'h30, 16'h0000, 0);

    // Randomized traffic with garbage on the inputs while busy
    for (int i = 0; i < 150; i++) begin
      txn(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), int'($urandom_range(0, 1)));
    end

    // Reset does not clear storage
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = 16'h0000;
    txn(1'b0, 8'h10, 16'h0000, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
